// File: rtl/xps2_keyctrl.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, assembles 11-bit frames,
// decodes make/break/extended sequences and queues make codes for the CPU.
module xps2_keyctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 10000,
    parameter int unsigned PARITY_CHK  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              sel,
    input  logic              we,
    input  logic              addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              key_rdy,
    output logic              err
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned FRAME_W = 11;
    localparam int unsigned ENTRY_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_clk_s1;
    logic                 r_clk_s2;
    logic                 r_dat_s1;
    logic                 r_dat_s2;
    logic                 r_clk_prev;

    logic [FRAME_W-1:0]   r_frame;
    logic [3:0]           r_bitcnt;
    logic [TMR_W-1:0]     r_timer;

    logic                 r_brk;
    logic                 r_ext;
    logic                 r_err;
    logic                 r_ovf;

    logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_fall;
    logic                 w_timeout;
    logic                 w_check;
    logic [7:0]           w_byte;
    logic                 w_valid;
    logic                 w_is_ext;
    logic                 w_is_brk;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_clr;
    logic                 w_full;
    logic                 w_do_push;
    logic                 w_drop;
    logic                 w_unused_data;

    // Two-flop synchronisers; lines idle high so the flops reset to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_clk_prev <= 1'b0;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
            r_clk_prev <= r_clk_s2;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_timeout = (r_timer == TMR_W'(TIMEOUT_CYC));
    assign w_check   = (r_state == ST_CHECK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_fall && !r_dat_s2) w_state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (w_fall && (r_bitcnt == 4'd10)) begin
                    w_state_nxt = ST_CHECK;
                end else if (!w_fall && w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CHECK: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Frame shifts in from the top so the start bit lands in bit 0 after 11 falls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame  <= '0;
            r_bitcnt <= '0;
            r_timer  <= '0;
        end else begin
            if (r_state == ST_IDLE && w_fall && !r_dat_s2) begin
                r_frame  <= {r_dat_s2, r_frame[FRAME_W-1:1]};
                r_bitcnt <= 4'd1;
            end else if (r_state == ST_SHIFT && w_fall) begin
                r_frame  <= {r_dat_s2, r_frame[FRAME_W-1:1]};
                r_bitcnt <= r_bitcnt + 4'd1;
            end

            if (r_state != ST_SHIFT || w_fall) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    assign w_byte   = r_frame[8:1];
    assign w_valid  = ~r_frame[0] & r_frame[10] & ((PARITY_CHK == 0) | (^r_frame[9:1]));
    assign w_is_ext = (w_byte == 8'hE0);
    assign w_is_brk = (w_byte == 8'hF0);

    assign w_push    = w_check & w_valid & ~w_is_ext & ~w_is_brk & ~r_brk;
    assign w_pop     = sel & ~we & ~addr & key_rdy;
    assign w_flush   = sel & we & addr & data_in[1];
    assign w_clr     = sel & we & addr & data_in[0];
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_do_push = w_push & ~w_flush & (~w_full | w_pop);
    assign w_drop    = w_push & ~w_flush & w_full & ~w_pop;

    // Protocol flags and sticky error/overflow; a new event wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
            r_err <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_flush) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (w_check) begin
                if (!w_valid) begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end else if (w_is_ext) begin
                    r_ext <= 1'b1;
                end else if (w_is_brk) begin
                    r_brk <= 1'b1;
                end else begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                end
            end

            if (w_check && !w_valid) begin
                r_err <= 1'b1;
            end else if (w_clr) begin
                r_err <= 1'b0;
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= {r_ext, w_byte};
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign key_rdy = (r_count != '0);
    assign err     = r_err;

    always_comb begin
        data_out = '0;
        if (sel) begin
            if (!addr) begin
                if (key_rdy) begin
                    data_out[9:0] = {1'b1, r_mem[r_rptr]};
                end
            end else begin
                data_out[6:0] = {r_ovf, r_err, (r_state == ST_IDLE), 4'(r_count)};
            end
        end
    end

    assign w_unused_data = ^data_in[DATA_W-1:2];

endmodule

// File: tb/tb_xps2_keyctrl.sv
// Directed bench for xps2_keyctrl: drives PS/2 frames and checks KEY/STATUS reads.
module tb_xps2_keyctrl;

    localparam int unsigned DATA_W = 32;
    localparam int          HALF   = 20;

    logic              clk;
    logic              rst;
    logic              ps2_clk;
    logic              ps2_data;
    logic              sel;
    logic              we;
    logic              addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              key_rdy;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rd;

    xps2_keyctrl dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .key_rdy  (key_rdy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        @(negedge clk) ps2_data = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Optional KEY read lands on the CHECK cycle: fall seen 3 edges after ps2_clk drops
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_at_check,
                              output logic [31:0] rd_val);
        rd_val = '0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b);
        @(negedge clk) ps2_data = stop;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (rd_at_check) begin
            repeat (3) @(negedge clk);
            sel = 1'b1; we = 1'b0; addr = 1'b0;
            #1 rd_val = data_out;
            @(negedge clk) sel = 1'b0;
            repeat (HALF - 4) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] b);
        logic [31:0] dummy;
        send_frame(b, 1'b1, 1'b0, dummy);
    endtask

    task automatic key_read(output logic [31:0] d);
        @(negedge clk) sel = 1'b1; we = 1'b0; addr = 1'b0;
        #1 d = data_out;
        @(negedge clk) sel = 1'b0;
    endtask

    task automatic status_read(output logic [31:0] d);
        @(negedge clk) sel = 1'b1; we = 1'b0; addr = 1'b1;
        #1 d = data_out;
        @(negedge clk) sel = 1'b0;
    endtask

    task automatic status_write(input logic [31:0] d);
        @(negedge clk) sel = 1'b1; we = 1'b1; addr = 1'b1; data_in = d;
        @(negedge clk) sel = 1'b0; we = 1'b0; data_in = '0;
    endtask

    initial begin
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        sel = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_key_rdy", 32'(key_rdy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        status_read(rd);  check("rst_status", rd, 32'h10);
        #1 check("unsel_data_out", data_out, 32'h0);

        // Break sequence consumed
        frame(8'h79); frame(8'hF0); frame(8'h79);
        status_read(rd);  check("t1_count", rd, 32'h11);
        key_read(rd);     check("t1_key", rd, 32'h279);
        #1 check("t1_key_rdy", 32'(key_rdy), 32'h0);
        key_read(rd);     check("t1_empty_key", rd, 32'h0);

        // Extended make and extended break
        frame(8'hE0); frame(8'h75); frame(8'hE0); frame(8'hF0); frame(8'h75);
        key_read(rd);     check("t2_key", rd, 32'h375);
        frame(8'h1C);
        key_read(rd);     check("t2_flags_clear", rd, 32'h21C);

        // Overflow with depth 4
        frame(8'h69); frame(8'h7A); frame(8'h6B); frame(8'h7C); frame(8'h7B);
        status_read(rd);  check("t3_status", rd, 32'h54);
        key_read(rd);     check("t3_k0", rd, 32'h269);
        key_read(rd);     check("t3_k1", rd, 32'h27A);
        key_read(rd);     check("t3_k2", rd, 32'h26B);
        key_read(rd);     check("t3_k3", rd, 32'h27C);
        status_read(rd);  check("t3_ovf_sticky", rd, 32'h50);
        status_write(32'h1);
        status_read(rd);  check("t3_ovf_clr", rd, 32'h10);

        // Bad stop bit
        send_frame(8'h5A, 1'b0, 1'b0, rd);
        #1 check("t4_err", 32'(err), 32'h1);
        status_read(rd);  check("t4_status", rd, 32'h30);
        status_write(32'h1);
        #1 check("t4_err_clr", 32'(err), 32'h0);

        // Flush clears queue and pending extended prefix
        frame(8'h1C); frame(8'h32); frame(8'hE0);
        status_read(rd);  check("flush_pre", rd, 32'h12);
        status_write(32'h2);
        status_read(rd);  check("flush_post", rd, 32'h10);
        frame(8'h1C);
        key_read(rd);     check("flush_ext_clr", rd, 32'h21C);

        // Timeout abandons a partial frame
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        repeat (12500) @(negedge clk);
        status_read(rd);  check("t5_stall_status", rd, 32'h10);
        frame(8'h7A);
        #1 check("t5_err", 32'(err), 32'h0);
        key_read(rd);     check("t5_key", rd, 32'h27A);

        // Reset mid-frame
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        frame(8'h7A);
        #1 check("t5r_err", 32'(err), 32'h0);
        key_read(rd);     check("t5r_key", rd, 32'h27A);

        // Push and pop together while full
        frame(8'h16); frame(8'h1E); frame(8'h26); frame(8'h25);
        status_read(rd);  check("t6_full", rd, 32'h14);
        send_frame(8'h5A, 1'b1, 1'b1, rd);
        check("t6_pop_at_check", rd, 32'h216);
        status_read(rd);  check("t6_status", rd, 32'h14);
        key_read(rd);     check("t6_k0", rd, 32'h21E);
        key_read(rd);     check("t6_k1", rd, 32'h226);
        key_read(rd);     check("t6_k2", rd, 32'h225);
        key_read(rd);     check("t6_tail", rd, 32'h25A);
        status_read(rd);  check("t6_empty", rd, 32'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
